// File: rtl/box_overlay.sv
// Overlays a solid-colour bounding-box border on an RGB888 LCD stream.
// The box is frozen once per frame at the falling edge of lcd_vs; outputs lag inputs by 2 clocks.
module box_overlay #(
   parameter int          H_ACTIVE  = 640,
   parameter int          V_ACTIVE  = 480,
   parameter int          LINE_W    = 2,
   parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lcd_vs,
   input  logic        lcd_hs,
   input  logic        lcd_de,
   input  logic [23:0] lcd_data,
   input  logic        draw_en,
   input  logic [11:0] hcount_l,
   input  logic [11:0] hcount_r,
   input  logic [11:0] vcount_l,
   input  logic [11:0] vcount_r,
   output logic        out_vs,
   output logic        out_hs,
   output logic        out_de,
   output logic [23:0] out_data,
   output logic        box_valid
);

   localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
   localparam logic [11:0] V_LIM = 12'(V_ACTIVE);
   localparam logic [11:0] LW2   = 12'(2 * LINE_W);
   localparam logic [12:0] LW13  = 13'(LINE_W);

   // The tracker produces left/top = -5 near the frame origin; treat the wrap as zero.
   function automatic logic [11:0] clamp_low(input logic [11:0] v);
      return (v >= 12'hF00) ? 12'd0 : v;
   endfunction

   function automatic logic [11:0] clamp_high(input logic [11:0] v, input logic [11:0] lim);
      return (v >= lim) ? (lim - 12'd1) : v;
   endfunction

   logic        vs_d0, vs_d1, de_d;
   logic        frame_start;
   logic [11:0] x_cnt, y_cnt;
   logic [11:0] sh_l, sh_r, sh_t, sh_b;
   logic [11:0] cl_l, cl_r, cl_t, cl_b;
   logic        nxt_valid;

   logic        vs_p1, hs_p1, vld_p1, act_p1;
   logic        in_x_p1, in_y_p1, edge_x_p1, edge_y_p1;
   logic [23:0] data_p1;
   logic        border_p1;

   assign frame_start = vs_d1 & ~vs_d0;

   always_comb begin
      cl_l      = clamp_low(hcount_l);
      cl_t      = clamp_low(vcount_l);
      cl_r      = clamp_high(hcount_r, H_LIM);
      cl_b      = clamp_high(vcount_r, V_LIM);
      nxt_valid = 1'b0;
      if (draw_en && (cl_r >= cl_l) && (cl_b >= cl_t))
         nxt_valid = ((cl_r - cl_l) >= LW2) && ((cl_b - cl_t) >= LW2);
   end

   // Frame-start detection, shadow box and pixel position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d0     <= 1'b0;
         vs_d1     <= 1'b0;
         de_d      <= 1'b0;
         x_cnt     <= 12'd0;
         y_cnt     <= 12'd0;
         sh_l      <= 12'd0;
         sh_r      <= 12'd0;
         sh_t      <= 12'd0;
         sh_b      <= 12'd0;
         box_valid <= 1'b0;
      end else begin
         vs_d0 <= lcd_vs;
         vs_d1 <= vs_d0;
         de_d  <= lcd_de;
         x_cnt <= lcd_de ? (x_cnt + 12'd1) : 12'd0;
         if (frame_start) begin
            y_cnt     <= 12'd0;
            sh_l      <= cl_l;
            sh_r      <= cl_r;
            sh_t      <= cl_t;
            sh_b      <= cl_b;
            box_valid <= nxt_valid;
         end else if (de_d && !lcd_de && (y_cnt != 12'hFFF)) begin
            y_cnt <= y_cnt + 12'd1;
         end
      end
   end

   // Stage 1: geometry compares, pixel and syncs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_p1     <= 1'b0;
         hs_p1     <= 1'b0;
         vld_p1    <= 1'b0;
         act_p1    <= 1'b0;
         in_x_p1   <= 1'b0;
         in_y_p1   <= 1'b0;
         edge_x_p1 <= 1'b0;
         edge_y_p1 <= 1'b0;
         data_p1   <= 24'h0;
      end else begin
         vs_p1     <= lcd_vs;
         hs_p1     <= lcd_hs;
         vld_p1    <= lcd_de;
         act_p1    <= box_valid & lcd_de;
         in_x_p1   <= (x_cnt >= sh_l) && (x_cnt <= sh_r);
         in_y_p1   <= (y_cnt >= sh_t) && (y_cnt <= sh_b);
         edge_x_p1 <= ({1'b0, x_cnt} < ({1'b0, sh_l} + LW13)) ||
                      (({1'b0, x_cnt} + LW13) > {1'b0, sh_r});
         edge_y_p1 <= ({1'b0, y_cnt} < ({1'b0, sh_t} + LW13)) ||
                      (({1'b0, y_cnt} + LW13) > {1'b0, sh_b});
         data_p1   <= lcd_data;
      end
   end

   assign border_p1 = act_p1 & in_x_p1 & in_y_p1 & (edge_x_p1 | edge_y_p1);

   // Stage 2: colour mux and blanking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vs   <= 1'b0;
         out_hs   <= 1'b0;
         out_de   <= 1'b0;
         out_data <= 24'h0;
      end else begin
         out_vs   <= vs_p1;
         out_hs   <= hs_p1;
         out_de   <= vld_p1;
         out_data <= vld_p1 ? (border_p1 ? BOX_COLOR : data_p1) : 24'h0;
      end
   end

endmodule

// File: tb/tb_box_overlay.sv
// Scoreboarded bench for box_overlay: directed frames with hand-derived boxes,
// a per-cycle expected stream queued by the driver and checked by a separate monitor.
module tb_box_overlay;

   localparam int LW = 2;

   typedef struct packed {
      logic        vs;
      logic        hs;
      logic        de;
      logic [23:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lcd_vs, lcd_hs, lcd_de, draw_en;
   logic [23:0] lcd_data;
   logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
   logic        out_vs, out_hs, out_de, box_valid;
   logic [23:0] out_data;

   exp_t expq[$];
   int   checks   = 0;
   int   failures = 0;
   int   mL, mR, mT, mB;
   logic mV;

   box_overlay #(.H_ACTIVE(640), .V_ACTIVE(480), .LINE_W(LW), .BOX_COLOR(24'hFF0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .lcd_vs(lcd_vs), .lcd_hs(lcd_hs), .lcd_de(lcd_de), .lcd_data(lcd_data),
      .draw_en(draw_en),
      .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
      .out_vs(out_vs), .out_hs(out_hs), .out_de(out_de), .out_data(out_data),
      .box_valid(box_valid)
   );

   always #5 clk = ~clk;

   // Outputs shown after posedge n-1 belong to the input captured at posedge n-2,
   // while the driver has already queued entries for n-1 and n.
   always @(negedge clk) begin
      exp_t e;
      if (expq.size() >= 3) begin
         e = expq.pop_front();
         checks++;
         if ({out_vs, out_hs, out_de, out_data} !== e) begin
            failures++;
            $display("FAIL stream t=%0t got vs=%0b hs=%0b de=%0b data=%06h exp vs=%0b hs=%0b de=%0b data=%06h",
                     $time, out_vs, out_hs, out_de, out_data, e.vs, e.hs, e.de, e.data);
         end
      end
   end

   function automatic logic [23:0] pix(input int x, input int y);
      logic [11:0] xx, yy;
      xx = 12'(x);
      yy = 12'(y);
      return {xx[7:0] ^ 8'h5A, yy[7:0], 8'h3C};
   endfunction

   function automatic logic border(input int x, input int y);
      return mV && (x >= mL) && (x <= mR) && (y >= mT) && (y <= mB) &&
             ((x < mL + LW) || (x > mR - LW) || (y < mT + LW) || (y > mB - LW));
   endfunction

   task automatic chk_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0b exp=%0b", name, got, exp);
      end
   endtask

   task automatic tick(input logic vs, input logic hs, input logic de,
                       input logic [23:0] d, input logic brd);
      exp_t e;
      lcd_vs   = vs;
      lcd_hs   = hs;
      lcd_de   = de;
      lcd_data = d;
      e = '0;
      if (rst_n) begin
         e.vs   = vs;
         e.hs   = hs;
         e.de   = de;
         e.data = de ? (brd ? 24'hFF0000 : d) : 24'h0;
      end
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [11:0] l, input logic [11:0] r,
                        input logic [11:0] t, input logic [11:0] b, input logic den,
                        input int el, input int er, input int et, input int eb, input logic ev,
                        input int wlen, input int mid, input int chg_line,
                        input logic [11:0] chg_r, input int rst_line);
      int  len;
      bit  wide;
      hcount_l = l;
      hcount_r = r;
      vcount_l = t;
      vcount_r = b;
      draw_en  = den;
      tick(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      mL = el; mR = er; mT = et; mB = eb; mV = ev;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      chk_bit("box_valid_frame", box_valid, ev);
      for (int y = 0; y < 480; y++) begin
         wide = (y <= 2) || (y >= mT - 1 && y <= mT + 2) || (y >= mB - 2 && y <= mB + 1) ||
                (y == mid) || (y == mid + 1) || (y == mid + 5);
         len = wide ? wlen : 3;
         if (y == chg_line) hcount_r = chg_r;
         for (int x = 0; x < len; x++) begin
            if (y == rst_line && x == 50) begin
               rst_n = 1'b0;
               foreach (expq[i]) expq[i] = '0;
               mV = 1'b0;
            end
            if (y == rst_line && x == 55) rst_n = 1'b1;
            tick(1'b0, 1'b0, 1'b1, pix(x, y), border(x, y));
            if (y == rst_line && x == 52) begin
               chk_bit("rst_box_valid", box_valid, 1'b0);
               chk_bit("rst_out_de", out_de, 1'b0);
            end
         end
         tick(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
         tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      end
      chk_bit("box_valid_end", box_valid, mV);
   endtask

   initial begin
      rst_n    = 1'b0;
      lcd_vs   = 1'b0;
      lcd_hs   = 1'b0;
      lcd_de   = 1'b0;
      lcd_data = 24'h0;
      draw_en  = 1'b0;
      hcount_l = 12'd0;
      hcount_r = 12'd0;
      vcount_l = 12'd0;
      vcount_r = 12'd0;
      mL = 0; mR = 0; mT = 0; mB = 0; mV = 1'b0;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      chk_bit("reset_box_valid", box_valid, 1'b0);
      chk_bit("reset_out_vs", out_vs, 1'b0);
      chk_bit("reset_out_data_zero", out_data == 24'h0, 1'b1);
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);

      // all-zero box: invalid
      frame(12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 0, 0, 0, 0, 1'b0, 20, 5, -1, 12'd0, -1);
      // basic box
      frame(12'd100, 12'd200, 12'd50, 12'd150, 1'b1, 100, 200, 50, 150, 1'b1, 203, 100, -1, 12'd0, -1);
      // underflowed left/top clamp to 0
      frame(12'hFFD, 12'd20, 12'hFFE, 12'd30, 1'b1, 0, 20, 0, 30, 1'b1, 23, 15, -1, 12'd0, -1);
      // left beyond right: invalid
      frame(12'd300, 12'd200, 12'd50, 12'd150, 1'b1, 300, 200, 50, 150, 1'b0, 303, 100, -1, 12'd0, -1);
      // right edge moves to 400 at line 100; this frame keeps 200
      frame(12'd100, 12'd200, 12'd50, 12'd150, 1'b1, 100, 200, 50, 150, 1'b1, 403, 100, 100, 12'd400, -1);
      frame(12'd100, 12'd400, 12'd50, 12'd150, 1'b1, 100, 400, 50, 150, 1'b1, 403, 100, -1, 12'd0, -1);
      // right/bottom clamp to 639/479, then the same with draw disabled
      frame(12'd600, 12'd700, 12'd470, 12'd600, 1'b1, 600, 639, 470, 479, 1'b1, 640, 475, -1, 12'd0, -1);
      frame(12'd600, 12'd700, 12'd470, 12'd600, 1'b0, 600, 639, 470, 479, 1'b0, 640, 475, -1, 12'd0, -1);
      // reset at line 240 kills the overlay for the rest of the frame
      frame(12'd100, 12'd200, 12'd200, 12'd300, 1'b1, 100, 200, 200, 300, 1'b1, 203, 240, -1, 12'd0, 240);
      frame(12'd100, 12'd200, 12'd200, 12'd300, 1'b1, 100, 200, 200, 300, 1'b1, 203, 240, -1, 12'd0, -1);

      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
